// File: rtl/thread_scheduler.sv
// Round-robin fetch sequencer for a barrel multithreaded pipeline: owns per-thread PC and stall state.
// Optional SCHED_PERF_CNT_EN adds saturating idle-cycle and per-thread issue counters.
//
// state | meaning
// RUN   | thread may be selected for fetch
// STALL | thread waiting on a cache fill, never selected
module thread_scheduler #(
    parameter int              N_THREADS = 8,
    parameter int              TID_W     = $clog2(N_THREADS),
    parameter int              PC_W      = 32,
    parameter logic [PC_W-1:0] RESET_PC  = 32'h1000,
    parameter logic [PC_W-1:0] EXC_PC    = 32'h2000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_THREADS-1:0]      stall_set,
    input  logic [N_THREADS-1:0]      stall_clr,
    input  logic [N_THREADS-1:0]      wb_pc_en,
    input  logic [PC_W-1:0]           wb_pc_data,
    input  logic                      exc_en,
    input  logic [TID_W-1:0]          exc_thread,
    output logic                      fetch_en,
    output logic [TID_W-1:0]          fetch_thread,
    output logic [PC_W-1:0]           fetch_pc,
    output logic [N_THREADS*PC_W-1:0] pc,
`ifdef SCHED_PERF_CNT_EN
    output logic [31:0]               idle_cycles,
    output logic [N_THREADS*32-1:0]   issue_cnt,
`endif
    output logic [N_THREADS-1:0]      stalled
);

    typedef enum logic {RUN = 1'b0, STALL = 1'b1} thr_state_t;

    thr_state_t              state_q [N_THREADS];
    thr_state_t              state_d [N_THREADS];
    logic [PC_W-1:0]         pc_q    [N_THREADS];
    logic [PC_W-1:0]         pc_d    [N_THREADS];
    logic [TID_W-1:0]        rr_last_q;
    logic                    fetch_en_q;
    logic [TID_W-1:0]        fetch_thread_q;
    logic [PC_W-1:0]         fetch_pc_q;

    logic [N_THREADS-1:0]    exc_hit;
    logic [N_THREADS-1:0]    elig;
    logic                    grant_vld;
    logic [TID_W-1:0]        grant_id;
    logic [TID_W-1:0]        idx;

    always_comb begin
        exc_hit = '0;
        elig    = '0;
        for (int i = 0; i < N_THREADS; i++) begin
            exc_hit[i] = exc_en && (exc_thread == TID_W'(i));
            elig[i]    = (state_q[i] == RUN) && !stall_set[i] && !wb_pc_en[i] && !exc_hit[i];
        end
    end

    // Search starts one past the last grant; k == N_THREADS wraps back onto rr_last itself.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        idx       = '0;
        for (int k = 1; k <= N_THREADS; k++) begin
            idx = rr_last_q + TID_W'(k);
            if (!grant_vld && elig[idx]) begin
                grant_vld = 1'b1;
                grant_id  = idx;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_THREADS; i++) begin
            pc_d[i]    = pc_q[i];
            state_d[i] = state_q[i];
            if (exc_hit[i]) begin
                pc_d[i]    = EXC_PC;
                state_d[i] = RUN;
            end else begin
                if (wb_pc_en[i])
                    pc_d[i] = wb_pc_data;
                else if (grant_vld && grant_id == TID_W'(i))
                    pc_d[i] = pc_q[i] + PC_W'(4);
                // set beats clear when both arrive together
                if (stall_set[i])
                    state_d[i] = STALL;
                else if (stall_clr[i])
                    state_d[i] = RUN;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_THREADS; i++) begin
                pc_q[i]    <= RESET_PC;
                state_q[i] <= RUN;
            end
            rr_last_q      <= TID_W'(N_THREADS - 1);
            fetch_en_q     <= 1'b0;
            fetch_thread_q <= '0;
            fetch_pc_q     <= '0;
        end else begin
            for (int i = 0; i < N_THREADS; i++) begin
                pc_q[i]    <= pc_d[i];
                state_q[i] <= state_d[i];
            end
            fetch_en_q <= grant_vld;
            if (grant_vld) begin
                rr_last_q      <= grant_id;
                fetch_thread_q <= grant_id;
                fetch_pc_q     <= pc_q[grant_id];
            end
        end
    end

`ifdef SCHED_PERF_CNT_EN
    logic [31:0] idle_q;
    logic [31:0] issue_q [N_THREADS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_q <= '0;
            for (int i = 0; i < N_THREADS; i++)
                issue_q[i] <= '0;
        end else begin
            if (!grant_vld && idle_q != 32'hFFFF_FFFF)
                idle_q <= idle_q + 32'd1;
            for (int i = 0; i < N_THREADS; i++)
                if (grant_vld && grant_id == TID_W'(i) && issue_q[i] != 32'hFFFF_FFFF)
                    issue_q[i] <= issue_q[i] + 32'd1;
        end
    end

    always_comb begin
        idle_cycles = idle_q;
        issue_cnt   = '0;
        for (int i = 0; i < N_THREADS; i++)
            issue_cnt[i*32 +: 32] = issue_q[i];
    end
`endif

    always_comb begin
        pc      = '0;
        stalled = '0;
        for (int i = 0; i < N_THREADS; i++) begin
            pc[i*PC_W +: PC_W] = pc_q[i];
            stalled[i]         = (state_q[i] == STALL);
        end
    end

    assign fetch_en     = fetch_en_q;
    assign fetch_thread = fetch_thread_q;
    assign fetch_pc     = fetch_pc_q;

endmodule

// File: tb/tb_thread_scheduler.sv
// Directed bench for thread_scheduler: rotation, stalls, redirects, exceptions, async reset.
module tb_thread_scheduler;

    localparam int N = 8;
    localparam int TW = 3;
    localparam int PW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    stall_set, stall_clr, wb_pc_en;
    logic [PW-1:0]   wb_pc_data;
    logic            exc_en;
    logic [TW-1:0]   exc_thread;
    logic            fetch_en;
    logic [TW-1:0]   fetch_thread;
    logic [PW-1:0]   fetch_pc;
    logic [N*PW-1:0] pc;
    logic [N-1:0]    stalled;
`ifdef SCHED_PERF_CNT_EN
    logic [31:0]     idle_cycles;
    logic [N*32-1:0] issue_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    thread_scheduler dut (
        .clk(clk), .rst(rst),
        .stall_set(stall_set), .stall_clr(stall_clr),
        .wb_pc_en(wb_pc_en), .wb_pc_data(wb_pc_data),
        .exc_en(exc_en), .exc_thread(exc_thread),
        .fetch_en(fetch_en), .fetch_thread(fetch_thread), .fetch_pc(fetch_pc),
        .pc(pc),
`ifdef SCHED_PERF_CNT_EN
        .idle_cycles(idle_cycles), .issue_cnt(issue_cnt),
`endif
        .stalled(stalled)
    );

    always #5 clk = ~clk;

    always @(posedge clk) assert ($onehot0(wb_pc_en)) else $error("wb_pc_en not one-hot");

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [PW-1:0] pc_of(input int t);
        return pc[t*PW +: PW];
    endfunction

    // Step until thread t is fetched (bounded); reports the pc it was fetched with.
    task automatic wait_fetch(input int t, input string tag, output logic [PW-1:0] got);
        bit found = 0;
        got = '0;
        for (int c = 0; c < 12 && !found; c++) begin
            step();
            if (fetch_en && fetch_thread == TW'(t)) begin
                found = 1;
                got   = fetch_pc;
            end
        end
        check({tag, "_found"}, 64'(found), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [PW-1:0] got;
        logic [PW-1:0] prev;
        int exp_seq [10];
        exp_seq = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1};
        rst = 1'b1;
        stall_set = '0; stall_clr = '0; wb_pc_en = '0; wb_pc_data = '0;
        exc_en = 1'b0; exc_thread = '0;
        #12;
        check("rst_fetch_en", 64'(fetch_en), 64'd0);
        check("rst_fetch_thread", 64'(fetch_thread), 64'd0);
        check("rst_fetch_pc", 64'(fetch_pc), 64'd0);
        check("rst_stalled", 64'(stalled), 64'd0);
        for (int t = 0; t < N; t++) check($sformatf("rst_pc%0d", t), 64'(pc_of(t)), 64'h1000);
        rst = 1'b0;

        // plain rotation
        for (int s = 0; s < 10; s++) begin
            step();
            check($sformatf("rot_en%0d", s), 64'(fetch_en), 64'd1);
            check($sformatf("rot_tid%0d", s), 64'(fetch_thread), 64'(exp_seq[s]));
            check($sformatf("rot_pc%0d", s), 64'(fetch_pc), (s < 8) ? 64'h1000 : 64'h1004);
        end

        // stall thread 2 just as it would be granted
        stall_set = 8'h04;
        step();
        stall_set = '0;
        check("stall2_tid", 64'(fetch_thread), 64'd3);
        check("stall2_flag", 64'(stalled[2]), 64'd1);
        check("stall2_pc", 64'(pc_of(2)), 64'h1004);
        for (int s = 0; s < 19; s++) begin
            step();
            check("stall2_skip", 64'(fetch_thread == 3'd2), 64'd0);
        end
        stall_clr = 8'h04;
        step();
        stall_clr = '0;
        check("clr2_flag", 64'(stalled[2]), 64'd0);
        wait_fetch(2, "resume2", got);
        check("resume2_pc", 64'(got), 64'h1004);

        // stall everything
`ifdef SCHED_PERF_CNT_EN
        prev = idle_cycles;
`endif
        stall_set = 8'hFF;
        step();
        stall_set = '0;
        check("allstall_en", 64'(fetch_en), 64'd0);
        check("allstall_flags", 64'(stalled), 64'hFF);
        step(); step();
        check("allstall_hold", 64'(fetch_en), 64'd0);
`ifdef SCHED_PERF_CNT_EN
        check("idle_inc", 64'(idle_cycles), 64'(prev + 32'd3));
`endif
        stall_clr = 8'h20;
        step();
        stall_clr = '0;
        check("clr5_edge_en", 64'(fetch_en), 64'd0);
        step();
        check("only5_en", 64'(fetch_en), 64'd1);
        check("only5_tid", 64'(fetch_thread), 64'd5);
        prev = fetch_pc;
        for (int s = 0; s < 3; s++) begin
            step();
            check("only5_tid_rep", 64'(fetch_thread), 64'd5);
            check("only5_pc_inc", 64'(fetch_pc), 64'(prev + 32'd4));
            prev = fetch_pc;
        end

        // release all; thread 5 is granted once more at that edge
        stall_clr = 8'hFF;
        step();
        stall_clr = '0;
        check("relall_tid", 64'(fetch_thread), 64'd5);
        for (int s = 0; s < 5; s++) begin
            step();
            check("pre_wb_tid", 64'(fetch_thread), 64'((6 + s) % 8));
        end
        wb_pc_en = 8'h08; wb_pc_data = 32'h2040;
        step();
        wb_pc_en = '0; wb_pc_data = '0;
        check("wb3_skip_tid", 64'(fetch_thread), 64'd4);
        check("wb3_pc", 64'(pc_of(3)), 64'h2040);
        wait_fetch(3, "wb3_first", got);
        check("wb3_first_pc", 64'(got), 64'h2040);
        wait_fetch(3, "wb3_second", got);
        check("wb3_second_pc", 64'(got), 64'h2044);

        // exception beats wb redirect and releases the stall
        stall_set = 8'h02;
        step();
        stall_set = '0;
        check("exc_pre_stall", 64'(stalled[1]), 64'd1);
        exc_en = 1'b1; exc_thread = 3'd1; wb_pc_en = 8'h02; wb_pc_data = 32'h3000;
        step();
        exc_en = 1'b0; exc_thread = '0; wb_pc_en = '0; wb_pc_data = '0;
        check("exc_pc1", 64'(pc_of(1)), 64'h2000);
        check("exc_stall1", 64'(stalled[1]), 64'd0);
        wait_fetch(1, "exc_fetch", got);
        check("exc_fetch_pc", 64'(got), 64'h2000);

        // asynchronous reset in mid-cycle
        step(); step();
        #3;
        rst = 1'b1;
        #1;
        check("arst_en", 64'(fetch_en), 64'd0);
        check("arst_tid", 64'(fetch_thread), 64'd0);
        check("arst_fpc", 64'(fetch_pc), 64'd0);
        check("arst_stalled", 64'(stalled), 64'd0);
        for (int t = 0; t < N; t++) check($sformatf("arst_pc%0d", t), 64'(pc_of(t)), 64'h1000);
        #2;
        rst = 1'b0;
        step();
        check("post_rst_en", 64'(fetch_en), 64'd1);
        check("post_rst_tid", 64'(fetch_thread), 64'd0);
        check("post_rst_pc", 64'(fetch_pc), 64'h1000);
        step();
        check("post_rst_tid2", 64'(fetch_thread), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
